// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte producers, with a done watchdog.
// Optional packet lock is compiled in when UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    input  logic [NUM_REQ-1:0]         req_last_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       tx_start_out,
    output logic [7:0]                 tx_data_out,
    input  logic                       tx_done_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_out,
    output logic                       busy_out,
    output logic                       err_timeout_out
);
    localparam int GW  = $clog2(NUM_REQ);
    localparam int GW1 = GW + 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit GAP_EN = (GAP_CYCLES > 0);
    localparam bit WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [GCW-1:0]     GAP_LAST = GCW'(GAP_EN ? GAP_CYCLES - 1 : 0);
    localparam logic [GCW-1:0]     GAP_ONE  = GCW'(1);
    localparam logic [WCW-1:0]     WD_LAST  = WCW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WCW-1:0]     WD_ONE   = WCW'(1);
    localparam logic [GW:0]        NUM_W    = GW1'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t         state_r;
    logic [GW-1:0]  ptr_r;
    logic [GW-1:0]  grant_r;
    logic [7:0]     tx_data_r;
    logic           tx_start_r;
    logic           busy_r;
    logic           err_r;
    logic [WCW-1:0] wd_cnt_r;
    logic [GCW-1:0] gap_cnt_r;

    logic [GW-1:0]  winner_s;
    logic           found_s;
    logic [GW:0]    pos_s;
    logic           hit_s;
    logic           accept_s;
    logic           abort_s;

`ifdef UART_ARB_LOCK_EN
    logic           lock_r;
    logic [GW-1:0]  lock_g_r;
`endif

    // Nearest valid requester after the last grant; scanning far-to-near lets the nearest hit win
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        pos_s    = '0;
        hit_s    = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos_s    = {1'b0, ptr_r} + GW1'(k);
            pos_s    = (pos_s >= NUM_W) ? (pos_s - NUM_W) : pos_s;
            hit_s    = req_valid_in[pos_s[GW-1:0]];
            found_s  = found_s | hit_s;
            winner_s = hit_s ? pos_s[GW-1:0] : winner_s;
        end
`ifdef UART_ARB_LOCK_EN
        found_s  = lock_r ? req_valid_in[lock_g_r] : found_s;
        winner_s = lock_r ? lock_g_r : winner_s;
`endif
    end

    assign accept_s = (state_r == ST_IDLE) && found_s;
    // A done arriving on the terminal count takes priority over the abort
    assign abort_s  = WD_EN && (state_r == ST_WAIT) && !tx_done_in && (wd_cnt_r == WD_LAST);

    // Ready is gated by reset so every output reads 0 while rst_n_in is low
    assign req_ready_out   = (accept_s && rst_n_in) ? (ONE_HOT0 << winner_s) : '0;
    assign tx_start_out    = tx_start_r;
    assign tx_data_out     = tx_data_r;
    assign grant_out       = grant_r;
    assign busy_out        = busy_r;
    assign err_timeout_out = err_r;

    // Sequencer: grant a byte, pulse start, wait for done or watchdog, then optional gap
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= ST_IDLE;
            ptr_r      <= GW'(NUM_REQ - 1);
            grant_r    <= '0;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            wd_cnt_r   <= '0;
            gap_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        tx_data_r  <= req_data_in[{winner_s, 3'b000} +: 8];
                        grant_r    <= winner_s;
                        ptr_r      <= winner_s;
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_START;
                    end else begin
                        tx_start_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_START: begin
                    tx_start_r <= 1'b0;
                    wd_cnt_r   <= '0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_in) begin
                        if (GAP_EN) begin
                            gap_cnt_r <= '0;
                            state_r   <= ST_GAP;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else if (abort_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_ONE;
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Packet lock: a byte without last pins arbitration to its requester until last or abort
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lock_r   <= 1'b0;
            lock_g_r <= '0;
        end else if (abort_s) begin
            lock_r   <= 1'b0;
        end else if (accept_s) begin
            lock_r   <= ~req_last_in[winner_s];
            lock_g_r <= winner_s;
        end else begin
            lock_r   <= lock_r;
        end
    end
`else
    logic last_unused_s;
    assign last_unused_s = ^req_last_in;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a uart_tx model and a start monitor.
module tb_uart_tx_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [3:0]  req_valid_in = 4'b0;
    logic [31:0] req_data_in = 32'h0;
    logic [3:0]  req_last_in = 4'b0;
    logic [3:0]  req_ready_out;
    logic        tx_start_out;
    logic [7:0]  tx_data_out;
    logic        tx_done_in = 1'b0;
    logic [1:0]  grant_out;
    logic        busy_out;
    logic        err_timeout_out;

    int          total = 0;
    int          bad = 0;
    logic [9:0]  sb_q[$];
    logic [8:0]  rbuf[4][32];
    int          rhead[4];
    int          rtail[4];
    logic [3:0]  acc = 4'b0;
    int          frame_len = 5;
    bit          uart_en = 1'b1;
    int          frame_left = 0;
    logic [7:0]  held = 8'h00;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .GAP_CYCLES(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in),
        .req_data_in(req_data_in),
        .req_last_in(req_last_in),
        .req_ready_out(req_ready_out),
        .tx_start_out(tx_start_out),
        .tx_data_out(tx_data_out),
        .tx_done_in(tx_done_in),
        .grant_out(grant_out),
        .busy_out(busy_out),
        .err_timeout_out(err_timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic put(input int r, input logic [7:0] d, input logic last);
        rbuf[r][rtail[r]] = {last, d};
        rtail[r]++;
    endtask

    task automatic exp_push(input logic [1:0] g, input logic [7:0] d);
        sb_q.push_back({g, d});
    endtask

    function automatic bit pending();
        for (int i = 0; i < 4; i++) begin
            if (rhead[i] != rtail[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || busy_out || pending()) && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL idle_%s: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tx_start_out && n < 100);
        total++;
        if (!tx_start_out) begin
            bad++;
            $display("FAIL start_%s: no start within %0d cycles, expected one", name, n);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(posedge clk_in);
            n++;
        end while (!tx_done_in && n < 100);
        total++;
        if (!tx_done_in) begin
            bad++;
            $display("FAIL done_%s: no done within %0d cycles, expected one", name, n);
        end
    endtask

    // Requester driver: capture accepts at the edge, present queue heads on the falling edge
    always begin
        @(posedge clk_in);
        acc = rst_n_in ? (req_valid_in & req_ready_out) : 4'b0;
        if (req_ready_out != 4'b0) chk("ready_onehot", $countones(req_ready_out), 1);
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) rhead[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            req_valid_in[i]        = (rhead[i] != rtail[i]);
            req_data_in[8*i +: 8]  = rbuf[i][rhead[i]][7:0];
            req_last_in[i]         = rbuf[i][rhead[i]][8];
        end
    end

    // uart_tx model: done pulse frame_len cycles after start, none when uart_en is clear
    always @(negedge clk_in) begin
        tx_done_in = 1'b0;
        if (!rst_n_in) begin
            frame_left = 0;
        end else if (tx_start_out) begin
            frame_left = uart_en ? frame_len : 0;
            held = tx_data_out;
        end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) begin
                tx_done_in = 1'b1;
                chk("data_hold", tx_data_out, held);
            end
        end
    end

    // Monitor: every start follows an accept by one cycle and matches the scoreboard head
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (acc != 4'b0 || tx_start_out) chk("start_after_accept", tx_start_out, acc != 4'b0);
            if (tx_start_out) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: grant=%0d data=%0h, expected no start", grant_out, tx_data_out);
                end else begin
                    chk("grant_data", {grant_out, tx_data_out}, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
            for (int j = 0; j < 32; j++) rbuf[i][j] = 9'h000;
        end
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_start", tx_start_out, 0);
        chk("rst_data", tx_data_out, 0);
        chk("rst_grant", grant_out, 0);
        chk("rst_err", err_timeout_out, 0);
        chk("rst_ready", req_ready_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // all four busy from reset: round robin starts at requester 0
        put(0, 8'h10, 1'b1); put(1, 8'h11, 1'b1); put(2, 8'h12, 1'b1); put(3, 8'h13, 1'b1);
        put(0, 8'h20, 1'b1);
        exp_push(2'd0, 8'h10); exp_push(2'd1, 8'h11); exp_push(2'd2, 8'h12);
        exp_push(2'd3, 8'h13); exp_push(2'd0, 8'h20);
        wait_idle("all4");

        // single byte, then a second requester waits out the 3-cycle gap
        put(0, 8'hA5, 1'b1);
        exp_push(2'd0, 8'hA5);
        wait_start("a5");
        put(1, 8'h5A, 1'b1);
        exp_push(2'd1, 8'h5A);
        wait_done("a5");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_in);
            #1;
            chk("gap_busy", busy_out, 1);
            chk("gap_ready", req_ready_out, 4'b0000);
        end
        @(negedge clk_in);
        #1;
        chk("gap_end_busy", busy_out, 0);
        chk("gap_end_ready", req_ready_out, 4'b0010);
        wait_idle("gap");

        // pointer at 2, requesters 2 and 0 valid: 0 then 2
        put(2, 8'hC3, 1'b1);
        exp_push(2'd2, 8'hC3);
        wait_idle("ptr2");
        put(0, 8'h01, 1'b1); put(2, 8'h02, 1'b1);
        exp_push(2'd0, 8'h01); exp_push(2'd2, 8'h02);
        wait_idle("wrap");

        // done on the watchdog terminal cycle wins
        frame_len = 16;
        put(3, 8'h99, 1'b1);
        exp_push(2'd3, 8'h99);
        wait_idle("coincide");
        chk("done_beats_timeout", err_timeout_out, 0);
        frame_len = 5;

        // no done at all: abort after 16 cycles in WAIT_DONE, then serve the next byte
        uart_en = 1'b0;
        put(1, 8'h77, 1'b1);
        exp_push(2'd1, 8'h77);
        wait_start("wd");
        repeat (16) @(negedge clk_in);
        chk("wd_err_early", err_timeout_out, 0);
        chk("wd_busy_early", busy_out, 1);
        @(negedge clk_in);
        chk("wd_err_set", err_timeout_out, 1);
        chk("wd_busy_clear", busy_out, 0);
        uart_en = 1'b1;
        put(3, 8'h3C, 1'b1);
        exp_push(2'd3, 8'h3C);
        wait_idle("after_wd");
        chk("err_sticky", err_timeout_out, 1);

        // async reset while waiting for done
        uart_en = 1'b0;
        put(0, 8'hE7, 1'b1);
        exp_push(2'd0, 8'hE7);
        wait_start("rst_mid");
        put(2, 8'h44, 1'b1);
        repeat (3) @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_busy", busy_out, 0);
        chk("arst_start", tx_start_out, 0);
        chk("arst_data", tx_data_out, 0);
        chk("arst_grant", grant_out, 0);
        chk("arst_err", err_timeout_out, 0);
        chk("arst_ready", req_ready_out, 0);
        uart_en = 1'b1;
        put(0, 8'h55, 1'b1);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        exp_push(2'd0, 8'h55); exp_push(2'd2, 8'h44);
        wait_idle("post_rst");

`ifdef UART_ARB_LOCK_EN
        // packet lock: requester 1 holds arbitration until its last byte
        put(0, 8'h60, 1'b1);
        exp_push(2'd0, 8'h60);
        wait_idle("lock_setup");
        put(1, 8'hB1, 1'b0); put(1, 8'hB2, 1'b0); put(1, 8'hB3, 1'b1);
        put(0, 8'h61, 1'b1);
        exp_push(2'd1, 8'hB1); exp_push(2'd1, 8'hB2); exp_push(2'd1, 8'hB3);
        exp_push(2'd0, 8'h61);
        wait_idle("lock");
`endif

        wait_idle("final");
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
